alu_ctrl: RTL
=============

# alu_ctrl

Command sequencer in front of the four registered ALU sub-units (arithmetic, logic, comparator, shift). It accepts one operation per valid/ready handshake and decodes the 4-bit function code into a one-hot unit enable plus a 2-bit unit function. It waits for the selected unit's completion flag, then registers the zero-extended result with a one-cycle OUT_VALID pulse. It owns the sharing of the operand bus and guarantees that only one unit is enabled at any time.

## Interface
- WIDTH, 8: operand width; A/B are [WIDTH-1:0]
- OUT_WIDTH, 16: result width; ALU_OUT is [OUT_WIDTH-1:0]
- TIMEOUT, 4: maximum WAIT cycles before error abort (≥1)

Ports:
- CLK  in  1  single clock; all logic is on its rising edge
- RST  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  controller can accept a command
- ALU_FUN  in  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] unit function
- A, B  in  WIDTH  operands
- OP_A, OP_B  out  WIDTH  registered operands driven to all units
- UNIT_FUN  out  2  registered ALU_FUN[1:0]
- ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable  out  1 each  one-hot unit enables
- ARITH_OUT, LOGIC_OUT, SHIFT_OUT  in  OUT_WIDTH  unit results
- CMP_OUT  in  4  comparator result
- ARITH_Flag, LOGIC_Flag, CMP_Flag, SHIFT_Flag  in  1 each  unit completion flags
- ALU_OUT  out  OUT_WIDTH  captured result, held until the next capture
- OUT_VALID  out  1  one-cycle pulse with each new ALU_OUT
- ERR  out  1  one-cycle pulse on timeout abort

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE: CMD_READY=1. On CMD_VALID, register A→OP_A, B→OP_B, ALU_FUN[1:0]→UNIT_FUN, and ALU_FUN[3:2]→sel; go to ISSUE.
- ISSUE: the enable selected by sel is 1 for exactly this cycle, and all other enables are 0. Clear the timeout counter. Go to WAIT.
- WAIT: all enables are 0. If the selected unit's flag is 1, capture its result into ALU_OUT (CMP_OUT zero-extended to OUT_WIDTH) and go to DONE. Otherwise increment the counter. When the counter reaches TIMEOUT, set ALU_OUT←0, pulse ERR, and go to DONE.
- DONE: OUT_VALID=1 (not asserted on timeout), CMD_READY=1. On CMD_VALID, capture a new command and go to ISSUE (back-to-back); otherwise go to IDLE.
- Flags of non-selected units are ignored in every state.
- CMD_READY is decoded from state: 1 in IDLE/DONE, 0 in ISSUE/WAIT. ALU_FUN, A and B are ignored while CMD_READY=0.
- Reset values: OP_A=0, OP_B=0, UNIT_FUN=0, all enables 0, ALU_OUT=0, OUT_VALID=0, ERR=0, CMD_READY=1, counter=0.
- Reset mid-operation returns to IDLE immediately (asynchronously), with all outputs at reset values. A late unit flag after reset is ignored.

## Timing
- Accept at edge k. Enable is high in cycle k+1. The unit registers at edge k+2, so its flag is high in cycle k+2. ALU_OUT/OUT_VALID are registered at edge k+3.
- Latency: 3 cycles from accept to OUT_VALID. Sustained throughput: 1 op per 3 cycles with back-to-back accept in DONE.
- Timeout: ERR is asserted TIMEOUT+2 cycles after the ISSUE cycle ends, when no flag arrives.
- OUT_VALID and ERR are never high in the same cycle. ALU_OUT is stable outside capture edges.

## Structure
- Package alu_ctrl_pkg: state enum (IDLE, ISSUE, WAIT, DONE); unit select constants SEL_ARITH=2'b00, SEL_LOGIC=2'b01, SEL_CMP=2'b10, SEL_SHIFT=2'b11.
- One natural sub-module: alu_unit_mux. It is combinational and, given sel, selects the flag and zero-extended result of the addressed unit.
- Timeout counter width: $clog2(TIMEOUT+1).

## Test plan
- Reset then cmp: ALU_FUN=4'b1010, A=8'd9, B=8'd3 with a model CMP unit. Required: CMP_Enable high for one cycle at k+1, ALU_OUT=16'd2, OUT_VALID at k+3, CMD_READY low during cycles k+1..k+2.
- Back-to-back: arith add 5+7, then a logic op presented with CMD_VALID held. Required: second accept occurs in DONE, no idle cycle, ALU_OUT=12 then the logic result, 3-cycle spacing between OUT_VALID pulses.
- One-hot check: cycle through all four selects. Required: exactly one enable is high per ISSUE, and no enable is high in IDLE/WAIT/DONE.
- Timeout: select shift with SHIFT_Flag tied 0, TIMEOUT=4. Required: ERR pulse, ALU_OUT=0, OUT_VALID stays 0, then return to IDLE.
- Spurious flag: LOGIC_Flag=1 while a cmp op is in WAIT and CMP_Flag=0. Required: no capture, and the capture occurs only when CMP_Flag rises.
- Reset mid-WAIT: drop RST while in WAIT. Required: all outputs return to reset values asynchronously, CMD_READY=1, and no OUT_VALID after release.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Unit select codes match ALU_FUN[3:2].
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_ARITH = 2'b00;
    localparam logic [1:0] SEL_LOGIC = 2'b01;
    localparam logic [1:0] SEL_CMP   = 2'b10;
    localparam logic [1:0] SEL_SHIFT = 2'b11;

    localparam int CMP_WIDTH = 4;

    // Enable vector bit order is {shift, cmp, logic, arith}.
    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        logic [3:0] oh;
        case (sel)
            SEL_ARITH: oh = 4'b0001;
            SEL_LOGIC: oh = 4'b0010;
            SEL_CMP:   oh = 4'b0100;
            SEL_SHIFT: oh = 4'b1000;
            default:   oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Command-side bus of the ALU sequencer: valid/ready command in, result out.
interface alu_ctrl_if #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 16
);
    import alu_ctrl_pkg::*;

    logic                 CMD_VALID;
    logic                 CMD_READY;
    logic [3:0]           ALU_FUN;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [OUT_WIDTH-1:0] ALU_OUT;
    logic                 OUT_VALID;
    logic                 ERR;

    modport master (
        output CMD_VALID, ALU_FUN, A, B,
        input  CMD_READY, ALU_OUT, OUT_VALID, ERR
    );

    modport slave (
        input  CMD_VALID, ALU_FUN, A, B,
        output CMD_READY, ALU_OUT, OUT_VALID, ERR
    );

endinterface

// File: rtl/alu_ctrl_unit_mux.sv
// Combinational selection of the addressed unit's completion flag and result;
// the 4-bit comparator result is zero-extended to the result width.
module alu_unit_mux
    import alu_ctrl_pkg::*;
#(
    parameter int OUT_WIDTH = 16
) (
    input  logic [1:0]           sel,
    input  logic                 arith_flag,
    input  logic                 logic_flag,
    input  logic                 cmp_flag,
    input  logic                 shift_flag,
    input  logic [OUT_WIDTH-1:0] arith_out,
    input  logic [OUT_WIDTH-1:0] logic_out,
    input  logic [OUT_WIDTH-1:0] shift_out,
    input  logic [CMP_WIDTH-1:0] cmp_out,
    output logic                 unit_flag,
    output logic [OUT_WIDTH-1:0] unit_res
);

    // Route only the addressed unit; every other flag is invisible downstream.
    always_comb begin
        unit_flag = 1'b0;
        unit_res  = '0;
        case (sel)
            SEL_ARITH: begin
                unit_flag = arith_flag;
                unit_res  = arith_out;
            end
            SEL_LOGIC: begin
                unit_flag = logic_flag;
                unit_res  = logic_out;
            end
            SEL_CMP: begin
                unit_flag = cmp_flag;
                unit_res  = {{(OUT_WIDTH-CMP_WIDTH){1'b0}}, cmp_out};
            end
            SEL_SHIFT: begin
                unit_flag = shift_flag;
                unit_res  = shift_out;
            end
            default: begin
                unit_flag = 1'b0;
                unit_res  = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// ALU command sequencer: accepts one op, pulses the one-hot unit enable,
// waits (bounded) for the unit flag and registers the result.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 16,
    parameter int TIMEOUT   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    alu_ctrl_if.slave            cmd,
    output logic [WIDTH-1:0]     OP_A,
    output logic [WIDTH-1:0]     OP_B,
    output logic [1:0]           UNIT_FUN,
    output logic                 ARITH_Enable,
    output logic                 LOGIC_Enable,
    output logic                 CMP_Enable,
    output logic                 SHIFT_Enable,
    input  logic [OUT_WIDTH-1:0] ARITH_OUT,
    input  logic [OUT_WIDTH-1:0] LOGIC_OUT,
    input  logic [OUT_WIDTH-1:0] SHIFT_OUT,
    input  logic [CMP_WIDTH-1:0] CMP_OUT,
    input  logic                 ARITH_Flag,
    input  logic                 LOGIC_Flag,
    input  logic                 CMP_Flag,
    input  logic                 SHIFT_Flag
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic [1:0]           unit_fun_q, unit_fun_d;
    logic [1:0]           sel_q, sel_d;
    logic [3:0]           en_q, en_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] alu_out_q, alu_out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 err_q, err_d;
    logic                 ready_q, ready_d;

    logic                 unit_flag_s;
    logic [OUT_WIDTH-1:0] unit_res_s;
    logic                 accept_s;

    alu_unit_mux #(.OUT_WIDTH(OUT_WIDTH)) u_mux (
        .sel        (sel_q),
        .arith_flag (ARITH_Flag),
        .logic_flag (LOGIC_Flag),
        .cmp_flag   (CMP_Flag),
        .shift_flag (SHIFT_Flag),
        .arith_out  (ARITH_OUT),
        .logic_out  (LOGIC_OUT),
        .shift_out  (SHIFT_OUT),
        .cmp_out    (CMP_OUT),
        .unit_flag  (unit_flag_s),
        .unit_res   (unit_res_s)
    );

    assign accept_s = cmd.CMD_VALID & ready_q;

    // Next-state and output decode; the enable is registered at accept so it is high only in ISSUE.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        unit_fun_d  = unit_fun_q;
        sel_d       = sel_q;
        en_d        = 4'b0000;
        cnt_d       = cnt_q;
        alu_out_d   = alu_out_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        ready_d     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    op_a_d     = cmd.A;
                    op_b_d     = cmd.B;
                    unit_fun_d = cmd.ALU_FUN[1:0];
                    sel_d      = cmd.ALU_FUN[3:2];
                    en_d       = sel_onehot(cmd.ALU_FUN[3:2]);
                    state_d    = ISSUE;
                end else begin
                    state_d    = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A flag in the final counted cycle still wins over the abort.
                if (unit_flag_s) begin
                    alu_out_d   = unit_res_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    alu_out_d = '0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE) || (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            unit_fun_q  <= 2'b00;
            sel_q       <= 2'b00;
            en_q        <= 4'b0000;
            cnt_q       <= '0;
            alu_out_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            unit_fun_q  <= unit_fun_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            alu_out_q   <= alu_out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    assign OP_A          = op_a_q;
    assign OP_B          = op_b_q;
    assign UNIT_FUN      = unit_fun_q;
    assign ARITH_Enable  = en_q[0];
    assign LOGIC_Enable  = en_q[1];
    assign CMP_Enable    = en_q[2];
    assign SHIFT_Enable  = en_q[3];
    assign cmd.CMD_READY = ready_q;
    assign cmd.ALU_OUT   = alu_out_q;
    assign cmd.OUT_VALID = out_valid_q;
    assign cmd.ERR       = err_q;

endmodule
